// File: rtl/wb_conbus_rr_pkg.sv
// Shared bus constants and types for the round-robin Wishbone interconnect.
// Imported by the arbiter, the top level and the bench.
package wb_conbus_rr_pkg;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int CW = 3;

  localparam logic [CW-1:0] CTI_CLASSIC = 3'b000;
  localparam logic [CW-1:0] CTI_INCR    = 3'b010;
  localparam logic [CW-1:0] CTI_EOB     = 3'b111;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWNED
  } arb_st_t;

  function automatic int unsigned rr_next(
    input int unsigned last,
    input int unsigned step,
    input int unsigned n
  );
    return (last + step) % n;
  endfunction

endpackage

// File: rtl/wb_conbus_rr_arb.sv
// Round-robin arbiter; the owner keeps the grant while its cyc is high.
// last_q always names the current (or most recent) owner.
module wb_conbus_rr_arb
  import wb_conbus_rr_pkg::*;
#(
  parameter int NM = 2
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [NM-1:0] req,
  output logic [NM-1:0] gnt
);

  localparam int IW = (NM > 1) ? $clog2(NM) : 1;

  arb_st_t       st_q;
  logic [NM-1:0] gnt_q;
  logic [IW-1:0] last_q;
  logic [IW-1:0] last_d;
  logic [NM-1:0] cand;
  logic [NM-1:0] pick;
  logic          found;

  // Scan from last+1 upward so the previous owner is served last.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    cand   = '0;
    last_d = last_q;
    for (int i = 1; i <= NM; i++) begin
      cand = NM'(1) << rr_next(32'(last_q), i, NM);
      if (!found && |(req & cand)) begin
        found  = 1'b1;
        pick   = cand;
        last_d = IW'(rr_next(32'(last_q), i, NM));
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      st_q   <= ARB_IDLE;
      gnt_q  <= '0;
      last_q <= IW'(NM - 1);
    end else if (st_q == ARB_OWNED && |(req & gnt_q)) begin
      st_q <= ARB_OWNED;
    end else if (found) begin
      st_q   <= ARB_OWNED;
      gnt_q  <= pick;
      last_q <= last_d;
    end else begin
      st_q  <= ARB_IDLE;
      gnt_q <= '0;
    end
  end

  assign gnt = gnt_q;

endmodule

// File: rtl/wb_conbus_rr.sv
// NM-master / NS-slave Wishbone classic shared bus with prefix decode,
// unmapped-address error and stall timeout.
module wb_conbus_rr
  import wb_conbus_rr_pkg::*;
#(
  parameter int                     NM       = 2,
  parameter int                     NS       = 6,
  parameter int                     S_ADDR_W = 3,
  parameter logic [NS*S_ADDR_W-1:0] S_ADDR   = 18'h2C688,
  parameter int                     TIMEOUT  = 255,
  parameter int                     TO_W     = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [NM*DW-1:0] m_dat_i,
  output logic [NM*DW-1:0] m_dat_o,
  input  logic [NM*AW-1:0] m_adr_i,
  input  logic [NM*CW-1:0] m_cti_i,
  input  logic [NM*SW-1:0] m_sel_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM-1:0]    m_cyc_i,
  input  logic [NM-1:0]    m_stb_i,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic [DW-1:0]    s_dat_o,
  output logic [AW-1:0]    s_adr_o,
  output logic [CW-1:0]    s_cti_o,
  output logic [SW-1:0]    s_sel_o,
  output logic             s_we_o,
  output logic [NS-1:0]    s_cyc_o,
  output logic [NS-1:0]    s_stb_o,
  input  logic [NS*DW-1:0] s_dat_i,
  input  logic [NS-1:0]    s_ack_i,
  input  logic [NS-1:0]    s_err_i,
  output logic [NM-1:0]    gnt_o
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [NM-1:0]       gnt;
  logic [AW-1:0]       adr_g;
  logic [DW-1:0]       dat_g;
  logic [CW-1:0]       cti_g;
  logic [SW-1:0]       sel_g;
  logic                cyc_g;
  logic                stb_g;
  logic [S_ADDR_W-1:0] pfx;
  logic                hit;
  logic [NS-1:0]       sel_oh;
  logic [DW-1:0]       rdat;
  logic                ack_s;
  logic                err_s;
  logic                err_q;
  logic                err_d;
  logic [TO_W-1:0]     to_q;
  logic [TO_W-1:0]     to_d;

  wb_conbus_rr_arb #(
    .NM(NM)
  ) u_arb (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .req    (m_cyc_i),
    .gnt    (gnt)
  );

  always_comb begin
    adr_g = '0;
    dat_g = '0;
    cti_g = '0;
    sel_g = '0;
    for (int k = 0; k < NM; k++) begin
      adr_g = adr_g | (m_adr_i[k*AW +: AW] & {AW{gnt[k]}});
      dat_g = dat_g | (m_dat_i[k*DW +: DW] & {DW{gnt[k]}});
      cti_g = cti_g | (m_cti_i[k*CW +: CW] & {CW{gnt[k]}});
      sel_g = sel_g | (m_sel_i[k*SW +: SW] & {SW{gnt[k]}});
    end
  end

  assign cyc_g = |(gnt & m_cyc_i);
  assign stb_g = |(gnt & m_stb_i);
  assign pfx   = adr_g[AW-1 -: S_ADDR_W];

  // With no grant nothing is selected, so the read path stays at zero.
  always_comb begin
    hit    = 1'b0;
    sel_oh = '0;
    rdat   = '0;
    ack_s  = 1'b0;
    err_s  = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (!hit && |gnt &&
          pfx == S_ADDR[i*S_ADDR_W +: S_ADDR_W]) begin
        hit       = 1'b1;
        sel_oh[i] = 1'b1;
        rdat      = s_dat_i[i*DW +: DW];
        ack_s     = s_ack_i[i];
        err_s     = s_err_i[i];
      end
    end
  end

  always_comb begin
    err_d = 1'b0;
    to_d  = '0;
    if (cyc_g && stb_g) begin
      if (!hit) begin
        err_d = ~err_q;
      end else if (!ack_s && !err_s && !err_q && TIMEOUT != 0) begin
        if (to_q == TO_LAST) err_d = 1'b1;
        else                 to_d  = to_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      err_q <= 1'b0;
      to_q  <= '0;
    end else begin
      err_q <= err_d;
      to_q  <= to_d;
    end
  end

  assign s_adr_o = adr_g;
  assign s_dat_o = dat_g;
  assign s_cti_o = cti_g;
  assign s_sel_o = sel_g;
  assign s_we_o  = |(gnt & m_we_i);
  assign s_cyc_o = sel_oh & {NS{cyc_g}};
  assign s_stb_o = sel_oh & {NS{stb_g}};
  assign m_dat_o = {NM{rdat}};
  assign m_ack_o = gnt & {NM{ack_s}};
  assign m_err_o = gnt & {NM{err_s | err_q}};
  assign gnt_o   = gnt;

endmodule

// File: tb/tb_wb_conbus_rr.sv
// Directed bench for wb_conbus_rr: per-cycle vector table plus
// hand sequences for timeout and asynchronous reset.
module tb_wb_conbus_rr;
  import wb_conbus_rr_pkg::*;

  localparam int NM = 2;
  localparam int NS = 6;

  localparam logic [31:0] A1 = 32'h2000_0010;
  localparam logic [31:0] A2 = 32'h4000_0000;
  localparam logic [31:0] A3 = 32'h6000_0000;
  localparam logic [31:0] AU = 32'hE000_0000;
  localparam logic [31:0] Z  = 32'h0;
  localparam logic [31:0] D1 = 32'hDEAD_BEEF;
  localparam logic [31:0] D2 = 32'h2222_2222;
  localparam logic [31:0] WM0 = 32'hA0A0_0001;
  localparam logic [31:0] WM1 = 32'hB0B0_0002;
  localparam logic [5:0] N6 = 6'b000000;
  localparam logic [5:0] S1 = 6'b000010;
  localparam logic [5:0] S2 = 6'b000100;
  localparam logic [1:0] G0 = 2'b00;
  localparam logic [1:0] G1 = 2'b01;
  localparam logic [1:0] G2 = 2'b10;
  localparam logic [1:0] CS = 2'b11;
  localparam logic [1:0] C_ = 2'b10;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic [NM*32-1:0] m_dat_i, m_dat_o, m_adr_i;
  logic [NM*3-1:0]  m_cti_i;
  logic [NM*4-1:0]  m_sel_i;
  logic [NM-1:0]    m_we_i, m_cyc_i, m_stb_i;
  logic [NM-1:0]    m_ack_o, m_err_o, gnt_o;
  logic [31:0]      s_dat_o, s_adr_o;
  logic [2:0]       s_cti_o;
  logic [3:0]       s_sel_o;
  logic             s_we_o;
  logic [NS-1:0]    s_cyc_o, s_stb_o, s_ack_i, s_err_i;
  logic [NS*32-1:0] s_dat_i;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic [1:0]  m0;
    logic [31:0] a0;
    logic [1:0]  m1;
    logic [31:0] a1;
    logic [5:0]  ack;
    logic [5:0]  err;
    logic [1:0]  gnt;
    logic [5:0]  scyc;
    logic [1:0]  mack;
    logic [1:0]  merr;
    logic [31:0] dat;
  } vec_t;

  vec_t tv[$];

  wb_conbus_rr dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
    .m_adr_i(m_adr_i), .m_cti_i(m_cti_i),
    .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_dat_o(s_dat_o), .s_adr_o(s_adr_o),
    .s_cti_o(s_cti_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o),
    .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .gnt_o(gnt_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input int r,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h, expected %h", nm, r, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    m_cyc_i = '0;
    m_stb_i = '0;
    s_ack_i = '0;
    s_err_i = '0;
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
  endtask

  task automatic check_idle(input string nm, input int r);
    chk({nm, "_gnt"}, r, 32'(gnt_o), Z);
    chk({nm, "_scyc"}, r, 32'(s_cyc_o), Z);
    chk({nm, "_mack"}, r, 32'(m_ack_o), Z);
    chk({nm, "_merr"}, r, 32'(m_err_o), Z);
    chk({nm, "_sadr"}, r, s_adr_o, Z);
    chk({nm, "_mdat"}, r, m_dat_o[31:0], Z);
  endtask

  initial begin
    int first, cnt, ack_at, ack_n;
    logic [31:0] e_adr, e_wd;
    logic [3:0]  e_sel;
    logic [2:0]  e_cti;
    logic        e_we;

    m_dat_i = {WM1, WM0};
    m_sel_i = {4'h3, 4'hF};
    m_we_i  = 2'b01;
    m_cti_i = {CTI_EOB, CTI_INCR};
    s_dat_i = {32'h5555_5555, 32'h4444_4444, 32'h3333_3333,
               D2, D1, 32'h1111_0000};
    s_ack_i = '0;
    s_err_i = '0;
    m_cyc_i = 2'b11;
    m_stb_i = 2'b11;
    m_adr_i = {A2, A1};
    sys_rst = 1'b1;

    #1;
    check_idle("rst0", 0);
    tick();
    check_idle("rst1", 0);

    // single master read, slave error
    tv.push_back('{1'b1, CS, A1, G0, A2, N6, N6, G0, N6, G0, G0, Z});
    tv.push_back('{1'b0, CS, A1, G0, A2, N6, N6, G1, S1, G0, G0, D1});
    tv.push_back('{1'b0, CS, A1, G0, A2, S1, N6, G1, S1, G1, G0, D1});
    tv.push_back('{1'b0, CS, A1, G0, A2, N6, S1, G1, S1, G0, G1, D1});
    tv.push_back('{1'b0, G0, A1, G0, A2, N6, N6, G1, N6, G0, G0, D1});
    tv.push_back('{1'b0, G0, A1, G0, A2, N6, N6, G0, N6, G0, G0, Z});
    // simultaneous requests, handover, pointer
    tv.push_back('{1'b1, CS, A1, CS, A2, N6, N6, G0, N6, G0, G0, Z});
    tv.push_back('{1'b0, CS, A1, CS, A2, N6, N6, G1, S1, G0, G0, D1});
    tv.push_back('{1'b0, G0, A1, CS, A2, N6, N6, G1, N6, G0, G0, D1});
    tv.push_back('{1'b0, G0, A1, CS, A2, N6, N6, G2, S2, G0, G0, D2});
    tv.push_back('{1'b0, CS, A1, CS, A2, N6, N6, G2, S2, G0, G0, D2});
    tv.push_back('{1'b0, G0, A1, G0, A2, N6, N6, G2, N6, G0, G0, D2});
    tv.push_back('{1'b0, G0, A1, G0, A2, N6, N6, G0, N6, G0, G0, Z});
    tv.push_back('{1'b0, CS, A1, CS, A2, N6, N6, G0, N6, G0, G0, Z});
    tv.push_back('{1'b0, CS, A1, CS, A2, N6, N6, G1, S1, G0, G0, D1});
    tv.push_back('{1'b0, G0, A1, CS, A2, N6, N6, G1, N6, G0, G0, D1});
    tv.push_back('{1'b0, CS, A1, CS, A2, N6, N6, G2, S2, G0, G0, D2});
    // grant lock over back-to-back acks
    tv.push_back('{1'b1, CS, A1, CS, A2, N6, N6, G0, N6, G0, G0, Z});
    tv.push_back('{1'b0, CS, A1, CS, A2, S1|S2, N6, G1, S1, G1, G0, D1});
    tv.push_back('{1'b0, CS, A1, CS, A2, S1|S2, N6, G1, S1, G1, G0, D1});
    tv.push_back('{1'b0, CS, A1, CS, A2, S1|S2, N6, G1, S1, G1, G0, D1});
    tv.push_back('{1'b0, G0, A1, CS, A2, N6, N6, G1, N6, G0, G0, D1});
    tv.push_back('{1'b0, G0, A1, CS, A2, N6, N6, G2, S2, G0, G0, D2});
    // unmapped prefix 7
    tv.push_back('{1'b1, CS, AU, G0, A2, N6, N6, G0, N6, G0, G0, Z});
    tv.push_back('{1'b0, CS, AU, G0, A2, N6, N6, G1, N6, G0, G0, Z});
    tv.push_back('{1'b0, CS, AU, G0, A2, N6, N6, G1, N6, G0, G1, Z});
    tv.push_back('{1'b0, CS, AU, G0, A2, N6, 6'h3F, G1, N6, G0, G0, Z});
    tv.push_back('{1'b0, C_, AU, G0, A2, N6, N6, G1, N6, G0, G1, Z});
    tv.push_back('{1'b0, C_, AU, G0, A2, N6, N6, G1, N6, G0, G0, Z});

    foreach (tv[r]) begin
      if (tv[r].rst) do_reset();
      m_cyc_i = {tv[r].m1[1], tv[r].m0[1]};
      m_stb_i = {tv[r].m1[0], tv[r].m0[0]};
      m_adr_i = {tv[r].a1, tv[r].a0};
      s_ack_i = tv[r].ack;
      s_err_i = tv[r].err;
      #1;
      e_adr = Z; e_wd = Z; e_sel = 4'h0; e_cti = 3'b000; e_we = 1'b0;
      if (tv[r].gnt == G1) begin
        e_adr = tv[r].a0; e_wd = WM0; e_sel = 4'hF;
        e_cti = CTI_INCR; e_we = 1'b1;
      end else if (tv[r].gnt == G2) begin
        e_adr = tv[r].a1; e_wd = WM1; e_sel = 4'h3;
        e_cti = CTI_EOB; e_we = 1'b0;
      end
      chk("gnt", r, 32'(gnt_o), 32'(tv[r].gnt));
      chk("s_cyc", r, 32'(s_cyc_o), 32'(tv[r].scyc));
      chk("s_stb", r, 32'(s_stb_o), 32'(tv[r].scyc));
      chk("m_ack", r, 32'(m_ack_o), 32'(tv[r].mack));
      chk("m_err", r, 32'(m_err_o), 32'(tv[r].merr));
      chk("m_dat0", r, m_dat_o[31:0], tv[r].dat);
      chk("m_dat1", r, m_dat_o[63:32], tv[r].dat);
      chk("s_adr", r, s_adr_o, e_adr);
      chk("s_dat", r, s_dat_o, e_wd);
      chk("s_ctl", r, {24'h0, s_cti_o, s_sel_o, s_we_o},
          {24'h0, e_cti, e_sel, e_we});
      tick();
    end

    // timeout: slave 3 never acks
    do_reset();
    m_adr_i = {A2, A3};
    m_cyc_i = 2'b01;
    m_stb_i = 2'b01;
    tick();
    chk("to_scyc", 0, 32'(s_cyc_o), 32'h08);
    first = 0;
    cnt   = 0;
    for (int n = 1; n <= 258; n++) begin
      if (m_err_o[0]) begin
        if (first == 0) first = n;
        cnt++;
      end
      if (n == 256) chk("to_cnt_clr", n, 32'(dut.to_q), Z);
      tick();
    end
    chk("to_err_cycle", 0, first, 256);
    chk("to_err_len", 0, cnt, 1);

    // ack exactly in cycle 255 beats the timeout
    m_cyc_i = '0;
    m_stb_i = '0;
    repeat (2) tick();
    m_cyc_i = 2'b01;
    m_stb_i = 2'b01;
    tick();
    cnt    = 0;
    ack_at = 0;
    ack_n  = 0;
    for (int n = 1; n <= 260; n++) begin
      s_ack_i = (n == 255) ? 6'b001000 : 6'b000000;
      #1;
      if (m_ack_o[0]) begin
        ack_at = n;
        ack_n++;
      end
      if (m_err_o != 2'b00) cnt++;
      tick();
    end
    s_ack_i = '0;
    chk("to_ack_cycle", 0, ack_at, 255);
    chk("to_ack_len", 0, ack_n, 1);
    chk("to_ack_no_err", 0, cnt, 0);

    // asynchronous reset while m1 owns the bus
    do_reset();
    m_adr_i = {A2, A1};
    m_cyc_i = 2'b10;
    m_stb_i = 2'b10;
    tick();
    tick();
    s_ack_i = S2;
    #1;
    chk("rm_gnt", 0, 32'(gnt_o), 32'(G2));
    chk("rm_ack", 0, 32'(m_ack_o), 32'(G2));
    #1;
    sys_rst = 1'b1;
    #1;
    check_idle("rm_async", 0);
    chk("rm_sstb", 0, 32'(s_stb_o), Z);
    tick();
    sys_rst = 1'b0;
    m_cyc_i = '0;
    m_stb_i = '0;
    s_ack_i = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_conbus_rr.md
Name: wb_conbus_rr

Overview:
- Parametrised Wishbone classic interconnect: NM masters to NS slaves over one shared bus.
- Round-robin arbitration, with the grant locked for the whole of the owning master's cycle.
- Per-slave address-prefix decode.
- Generates a bus error for unmapped addresses and for slaves that stall past a timeout.
- Successor to the fixed 2x7 bus in the SoC top level: one instance replaces it for any lm32 plus DMA-master configuration.

Parameters:
- NM, 2: number of masters (1..8).
- NS, 6: number of slaves (1..16).
- S_ADDR_W, 3: width of the decoded address prefix, taken from adr[31:32-S_ADDR_W].
- S_ADDR, 18'h2C688: packed NS*S_ADDR_W prefixes. Slave i occupies bits [i*S_ADDR_W +: S_ADDR_W]. The default maps slave i to prefix i.
- TIMEOUT, 255: stall cycles without ack or err before the block generates an error. 0 disables the timeout.
- TO_W, 8: timeout counter width. Must satisfy 2^TO_W > TIMEOUT.

Ports:
- sys_clk, in, 1: clock.
- sys_rst, in, 1: reset, asynchronous, active-high.
- m_dat_i, in, NM*32: master write data. Master k uses slice [k*32 +: 32], and the same slicing applies to every m_* vector.
- m_dat_o, out, NM*32: read data, broadcast to all masters.
- m_adr_i, in, NM*32: master address.
- m_cti_i, in, NM*3: master cycle type identifier.
- m_sel_i, in, NM*4: master byte select.
- m_we_i, m_cyc_i, m_stb_i, in, NM each: master control.
- m_ack_o, m_err_o, out, NM each: master termination.
- s_dat_o, out, 32: shared write data to slaves.
- s_adr_o, out, 32: shared address to slaves.
- s_cti_o, out, 3: shared cycle type to slaves.
- s_sel_o, out, 4: shared byte select to slaves.
- s_we_o, out, 1: shared write enable to slaves.
- s_cyc_o, s_stb_o, out, NS each: per-slave strobes.
- s_dat_i, in, NS*32: slave read data.
- s_ack_i, s_err_i, in, NS each: slave termination.
- gnt_o, out, NM: current one-hot grant (debug).

Behaviour:
- Reset (asynchronous):
  - gnt=0, last-owner pointer=NM-1 (master 0 has first priority), timeout counter=0, err_q=0.
  - All outputs are therefore 0: shared outputs are AND-masked by the grant, so no master bus is visible.
- Arbiter, two states: IDLE (gnt=0) and OWNED (gnt one-hot).
  - OWNED with m_cyc_i[owner]=1: grant held, regardless of other requests.
  - Owner's cyc=0, or state IDLE: pick the first requester scanning from last+1 upward, modulo NM. The new gnt is registered.
  - Latency: cyc rising in IDLE gives a grant on the next edge.
  - Handover: owner drops cyc at cycle t; the new owner is granted at t+1. There are no dead cycles beyond that.
  - No requesters: return to IDLE.
  - last is updated whenever a grant is issued.
- Shared bus: s_adr_o, s_dat_o, s_cti_o, s_sel_o and s_we_o are the granted master's fields, or 0 when there is no grant.
- Decode:
  - sel[i] = (s_adr_o prefix == S_ADDR slot i). The first match wins if slots are duplicated.
  - s_cyc_o[i] = cyc_g & sel[i]; s_stb_o[i] = stb_g & sel[i]. Unselected slaves see cyc=stb=0.
- Read data and termination:
  - m_dat_o = s_dat_i of the selected slave, else 0.
  - m_ack_o[g] = gnt[g] & s_ack_i[sel]. Acks from unselected slaves are ignored.
  - m_err_o[g] = gnt[g] & (s_err_i[sel] | err_q).
- Unmapped access:
  - err_q is set when cyc_g & stb_g & no sel & ~err_q; otherwise err_q is 0.
  - Result: a single-cycle err, one cycle after stb. It repeats only if stb is still asserted two cycles later.
- Timeout:
  - The counter increments while cyc_g & stb_g & mapped & ~ack & ~err.
  - It clears on ack, on err, on stb=0, or on a grant change.
  - On reaching TIMEOUT it pulses err_q for one cycle and clears.
  - An ack arriving in the same cycle as the timeout wins: no err is generated.
- Termination mid-cycle:
  - A master that drops cyc mid-transfer loses the grant next cycle.
  - Pending err_q and the counter are cleared.

Decomposition:
- Shared include wb_defs.vh:
  - CTI constants: CLASSIC=3'b000, INCR=3'b010, EOB=3'b111.
  - Bus widths: data 32, adr 32, sel 4, cti 3.
- Sub-module wb_conbus_rr_arb: round-robin arbiter and grant lock.
  - Parameter NM; ports sys_clk, sys_rst, req[NM], gnt[NM].
- Decode, muxing and timeout stay in the top module.

Test Plan:
- Single master, mapped read: after reset, m0 reads 32'h2000_0010 → gnt_o=2'b01 next cycle; s_cyc_o/s_stb_o=6'b000010. Slave 1 returns 32'hDEADBEEF with ack on its 2nd stb cycle → m_ack_o[0]=1 for one cycle, m_dat_o=32'hDEADBEEF.
- Simultaneous requests: m0 and m1 raise cyc on the same edge after reset → m0 granted first. m0 drops cyc at t → gnt_o=2'b10 at t+1. Both request again → m0 wins, because the round-robin pointer now sits at master 1.
- Grant lock: m0 holds cyc across 3 back-to-back acks while m1 requests → gnt_o stays 2'b01 throughout; m1 never sees ack.
- Unmapped: m0 accesses 32'hE000_0000 (prefix 7) → all s_cyc_o=0; m_err_o[0]=1 exactly one cycle after stb, then 0.
- Timeout: slave 3 never acks → m_err_o[0] pulses in cycle 256 after stb, counter returns to 0. Repeat with ack in exactly cycle 255 → ack only, no err.
- Reset mid-transfer: assert sys_rst while m1 owns the bus → gnt_o=0, every s_cyc_o=0 and m_ack_o/m_err_o=0 immediately, without waiting for a clock edge.
